// File: rtl/count_seq_ctrl.sv
// Sequencing controller for the 4-bit up-counter: clears it, counts up to a target,
// holds for a programmed number of cycles, then pulses done. Watchdog flags a stuck counter.
module count_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  target,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [WIDTH-1:0]  count_value,
  output logic              count_up,
  output logic              count_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // A healthy counter matches within 2^WIDTH+1 COUNT cycles; the watchdog trips on the next one.
  localparam int WD_W = WIDTH + 2;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(2 ** WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    HOLD,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              clrPulse_q, clrPulse_d;
  logic              match;

  assign match       = (count_value == target_q);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign count_reset = reset | (state_q == CLEAR) | clrPulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      hold_q     <= '0;
      holdCnt_q  <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      clrPulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      hold_q     <= hold_d;
      holdCnt_q  <= holdCnt_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      clrPulse_q <= clrPulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    hold_d     = hold_q;
    holdCnt_d  = holdCnt_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    clrPulse_d = 1'b0;
    count_up   = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = target;
          hold_d   = hold_cycles;
          err_d    = 1'b0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        wdog_d  = '0;
        state_d = COUNT;
      end
      COUNT: begin
        count_up = !match;
        wdog_d   = wdog_q + 1'b1;
        if (match) begin
          if (hold_q != '0) begin
            holdCnt_d = hold_q;
            state_d   = HOLD;
          end else begin
            state_d = DONE;
          end
        end else if (wdog_q == WD_LAST) begin
          err_d      = 1'b1;
          clrPulse_d = 1'b1;
          state_d    = IDLE;
        end
      end
      HOLD: begin
        if (holdCnt_q <= HOLD_W'(1)) begin
          state_d = DONE;
        end else begin
          holdCnt_d = holdCnt_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks the watchdog, so a simultaneous trip must not touch err.
    if (busy && abort) begin
      state_d    = IDLE;
      clrPulse_d = 1'b1;
      err_d      = err_q;
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: a behavioural counter closes the loop, and a queue of
// per-cycle expectations (with the stimulus to apply that cycle) drives each scenario.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] target = '0;
  logic [3:0] hold_cycles = '0;
  logic [3:0] count_value = '0;
  logic       count_up, count_reset, busy, done, err;
  logic       stuck = 1'b0;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int         cyc;
    logic [4:0] outs;
    logic       cvValid;
    logic [3:0] cv;
    logic       drvStart;
    logic       drvAbort;
    logic       drvReset;
    logic       drvStuck;
    logic [3:0] tgt;
    logic [3:0] hld;
  } expT;

  expT expQ[$];

  count_seq_ctrl #(.WIDTH(4), .HOLD_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .target(target),
    .hold_cycles(hold_cycles),
    .count_value(count_value),
    .count_up(count_up),
    .count_reset(count_reset),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Counter under control; "stuck" models a broken counter frozen at 2.
  always @(posedge clk) begin
    if (stuck) count_value <= 4'd2;
    else if (count_reset) count_value <= 4'd0;
    else if (count_up) count_value <= count_value + 4'd1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  function automatic expT mk(int cyc, logic [4:0] outs, logic cvValid, logic [3:0] cv);
    expT e;
    e.cyc = cyc; e.outs = outs; e.cvValid = cvValid; e.cv = cv;
    e.drvStart = 1'b0; e.drvAbort = 1'b0; e.drvReset = 1'b0; e.drvStuck = 1'b0;
    e.tgt = '0; e.hld = '0;
    return e;
  endfunction

  function automatic expT withStart(expT eIn, logic [3:0] t, logic [3:0] h);
    expT e = eIn;
    e.drvStart = 1'b1; e.tgt = t; e.hld = h;
    return e;
  endfunction

  // Expected {busy,count_up,done,count_reset,err} per cycle after a start at edge 0.
  function automatic void pushRun(int t, int h, int lastCyc);
    expT e;
    for (int c = 1; c <= t + 3 + h && c <= lastCyc; c++) begin
      if (c == 1) e = mk(c, 5'b10010, 1'b0, 4'd0);
      else if (c <= t + 2) e = mk(c, {1'b1, (c < t + 2) ? 1'b1 : 1'b0, 3'b000}, 1'b1, 4'(c - 2));
      else if (c <= t + 2 + h) e = mk(c, 5'b10000, 1'b1, 4'(t));
      else e = mk(c, 5'b10100, 1'b1, 4'(t));
      expQ.push_back(e);
    end
  endfunction

  task automatic applyStimulus(expT e);
    start = e.drvStart;
    abort = e.drvAbort;
    reset = e.drvReset;
    stuck = e.drvStuck;
    if (e.drvStart) begin
      target = e.tgt;
      hold_cycles = e.hld;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    expT e;
    reset = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back(mk(0, 5'b00010, 1'b1, 4'd0));
    expQ.push_back(mk(1, 5'b00000, 1'b1, 4'd0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL reset cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL reset cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_basic;
    expT e;
    expQ.push_back(withStart(mk(0, 5'b00000, 1'b1, 4'd0), 4'd5, 4'd3));
    pushRun(5, 3, 99);
    expQ.push_back(mk(12, 5'b00000, 1'b1, 4'd5));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL basic cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL basic cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_zero_and_full;
    expT e;
    expQ.push_back(withStart(mk(0, 5'b00000, 1'b0, 4'd0), 4'd0, 4'd0));
    pushRun(0, 0, 99);
    expQ.push_back(withStart(mk(4, 5'b00000, 1'b1, 4'd0), 4'd15, 4'd0));
    pushRun(15, 0, 99);
    expQ.push_back(mk(19, 5'b00000, 1'b1, 4'd15));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL zero_full cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL zero_full cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_abort;
    expT e;
    int idx;
    expQ.push_back(withStart(mk(0, 5'b00000, 1'b0, 4'd0), 4'd10, 4'd2));
    pushRun(10, 2, 6);
    idx = expQ.size() - 1;
    e = expQ[idx];
    e.drvAbort = 1'b1;
    expQ[idx] = e;
    expQ.push_back(mk(7, 5'b00010, 1'b1, 4'd5));
    expQ.push_back(mk(8, 5'b00000, 1'b1, 4'd0));
    expQ.push_back(mk(9, 5'b00000, 1'b1, 4'd0));
    expQ.push_back(mk(10, 5'b00000, 1'b1, 4'd0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL abort cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL abort cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_ignored_inputs;
    expT e;
    int base;
    e = mk(0, 5'b00000, 1'b1, 4'd0);
    e.drvAbort = 1'b1;
    expQ.push_back(e);
    expQ.push_back(withStart(mk(0, 5'b00000, 1'b1, 4'd0), 4'd6, 4'd1));
    base = expQ.size();
    pushRun(6, 1, 99);
    e = expQ[base + 3];
    e = withStart(e, 4'd2, 4'd0);
    expQ[base + 3] = e;
    expQ.push_back(mk(11, 5'b00000, 1'b1, 4'd6));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL ignored cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL ignored cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_watchdog;
    expT e;
    e = withStart(mk(0, 5'b00000, 1'b0, 4'd0), 4'd7, 4'd0);
    e.drvStuck = 1'b1;
    expQ.push_back(e);
    e = mk(1, 5'b10010, 1'b1, 4'd2);
    e.drvStuck = 1'b1;
    expQ.push_back(e);
    for (int c = 2; c <= 19; c++) begin
      e = mk(c, 5'b11000, 1'b1, 4'd2);
      e.drvStuck = 1'b1;
      expQ.push_back(e);
    end
    e = mk(20, 5'b00011, 1'b1, 4'd2);
    e.drvStuck = 1'b1;
    expQ.push_back(e);
    expQ.push_back(mk(21, 5'b00001, 1'b1, 4'd2));
    expQ.push_back(withStart(mk(22, 5'b00001, 1'b1, 4'd2), 4'd2, 4'd0));
    pushRun(2, 0, 99);
    expQ.push_back(mk(6, 5'b00000, 1'b1, 4'd2));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL watchdog cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL watchdog cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  task automatic test_back_to_back;
    expT e;
    int idx;
    expQ.push_back(withStart(mk(0, 5'b00000, 1'b0, 4'd0), 4'd3, 4'd4));
    pushRun(3, 4, 7);
    idx = expQ.size() - 1;
    e = expQ[idx];
    e.drvReset = 1'b1;
    expQ[idx] = e;
    expQ.push_back(mk(8, 5'b00010, 1'b1, 4'd0));
    expQ.push_back(withStart(mk(9, 5'b00000, 1'b1, 4'd0), 4'd2, 4'd1));
    pushRun(2, 1, 99);
    expQ.push_back(withStart(mk(7, 5'b00000, 1'b1, 4'd2), 4'd1, 4'd0));
    pushRun(1, 0, 99);
    expQ.push_back(mk(5, 5'b00000, 1'b1, 4'd1));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      assertCount++;
      if ({busy, count_up, done, count_reset, err} !== e.outs) begin
        failCount++;
        $display("[TB] FAIL mid_reset_b2b cyc%0d outs{busy,up,done,clr,err}: got %b expected %b", e.cyc, {busy, count_up, done, count_reset, err}, e.outs);
      end
      if (e.cvValid) begin
        assertCount++;
        if (count_value !== e.cv) begin
          failCount++;
          $display("[TB] FAIL mid_reset_b2b cyc%0d count_value: got %0d expected %0d", e.cyc, count_value, e.cv);
        end
      end
      applyStimulus(e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_full();
    test_abort();
    test_ignored_inputs();
    test_watchdog();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Sequencing controller for the team's 4-bit up-counter FSM (CountUP / CountValue interface).
- On a start command it clears the counter, then enables counting until CountValue equals a programmed target.
- It then holds the counter idle for a programmed number of cycles and signals completion.
- It sits between a command source (bench or control logic) and the counter; it is the only driver of the counter's enable and reset.

Parameters:
WIDTH, 4, counter width; must match the counter's CountValue width.
HOLD_W, 4, width of the hold-cycle count.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  command strobe; sampled only in IDLE
abort  input  1  cancel the current sequence; sampled only when busy=1
target  input  WIDTH  count value at which counting stops; latched on accepted start
hold_cycles  input  HOLD_W  idle cycles after target is reached; latched on accepted start
count_value  input  WIDTH  feedback from the counter's CountValue
count_up  output  1  drives the counter's CountUP
count_reset  output  1  drives the counter's reset
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a sequence completes normally
err  output  1  sticky watchdog error flag

Behaviour:
- Counter contract: the counter increments by 1, wrapping modulo 2^WIDTH, on each rising edge where count_up=1. count_reset=1 at an edge clears it to 0.
- On reset=1 at an edge:
  - state <= IDLE.
  - target_q, hold_q, hold counter and watchdog counter <= 0.
  - err <= 0.
  - count_reset is also asserted combinationally while reset=1, so the counter clears in the same cycle.
  - All other outputs are 0.
- States: IDLE, CLEAR, COUNT, HOLD, DONE.
- IDLE:
  - busy=0, count_up=0.
  - When start=1: latch target and hold_cycles, clear err, go to CLEAR.
  - abort is ignored in IDLE.
- CLEAR:
  - count_reset=1 for exactly one cycle.
  - Next state is COUNT.
- COUNT:
  - count_up = (count_value != target_q), combinational.
  - When count_value == target_q, count_up=0 that cycle. Next state is HOLD if hold_q != 0, otherwise DONE.
  - target_q=0 spends one COUNT cycle with count_up=0.
- HOLD:
  - count_up=0.
  - Down-counter loaded with hold_q on entry. Stay exactly hold_q cycles, then go to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - The counter is not cleared; count_value stays at target.
- Latency with start sampled at edge 0, target T, hold H:
  - CLEAR occupies cycle 1.
  - COUNT occupies cycles 2..T+2.
  - HOLD occupies cycles T+3..T+2+H.
  - done is high in cycle T+3+H.
- abort=1 in any busy state: next state is IDLE, count_reset=1 for one cycle (registered), no done pulse, err unchanged.
- start while busy is ignored. A new start in the cycle after DONE is accepted.
- Watchdog:
  - Counts COUNT-state cycles.
  - If it reaches 2^WIDTH+2 without a match (broken counter), err <= 1, state <= IDLE, count_reset pulsed for one cycle, no done.
  - err stays set until the next accepted start or reset.
- Priority within a cycle: reset > abort > watchdog > normal transition.
- Mid-operation reset behaves identically to power-on reset.

Test Plan:
1. Basic run: reset for 1 cycle, then start with target=5, hold=3 against the real counter -> count_up high for exactly 5 cycles; count_value ends at 5; done pulses once in cycle 11 after the start edge; busy high cycles 1..11.
2. Zero cases: target=0, hold=0 -> one CLEAR cycle, one COUNT cycle with count_up=0, done in cycle 3; target=15, hold=0 -> 15 count_up cycles, no wrap, count_value=15.
3. Abort: start target=10; assert abort when count_value=4 -> next cycle IDLE; count_reset pulses once; count_value=0; no done; err=0.
4. Ignored inputs: start pulsed during COUNT, and abort pulsed in IDLE -> no change to latched target, state, or outputs.
5. Watchdog: replace the counter with a model stuck at 2, target=7 -> after 18 COUNT cycles err=1, busy=0, no done; next start clears err.
6. Mid-run reset: reset=1 during HOLD -> next cycle all outputs 0 except count_reset (high while reset=1); state IDLE; back-to-back start after DONE runs correctly.
